// File: rtl/tilelink_ul_slave_mem.sv
// TL-UL slave: A-channel requests hit a word-addressed memory, responses queue up for the D channel.
// Optional address range check is compiled in with `define TL_UL_SLAVE_ADDR_CHECK_EN.
module tilelink_ul_slave_mem #(
  parameter int                     TL_ADDR_WIDTH   = 32,
  parameter int                     TL_DATA_WIDTH   = 32,
  parameter int                     TL_STRB_WIDTH   = TL_DATA_WIDTH / 8,
  parameter int                     TL_SOURCE_WIDTH = 4,
  parameter int                     TL_SINK_WIDTH   = 1,
  parameter int                     TL_SIZE_WIDTH   = 3,
  parameter int                     MEM_DEPTH       = 256,
  parameter logic [TL_ADDR_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int                     RSP_DEPTH       = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       a_valid_i,
  output logic                       a_ready_o,
  input  logic [2:0]                 a_opcode_i,
  input  logic [2:0]                 a_param_i,
  input  logic [TL_ADDR_WIDTH-1:0]   a_address_i,
  input  logic [TL_SIZE_WIDTH-1:0]   a_size_i,
  input  logic [TL_STRB_WIDTH-1:0]   a_mask_i,
  input  logic [TL_DATA_WIDTH-1:0]   a_data_i,
  input  logic [TL_SOURCE_WIDTH-1:0] a_source_i,
  output logic                       d_valid_o,
  input  logic                       d_ready_i,
  output logic [2:0]                 d_opcode_o,
  output logic [2:0]                 d_param_o,
  output logic [TL_SIZE_WIDTH-1:0]   d_size_o,
  output logic [TL_SINK_WIDTH-1:0]   d_sink_o,
  output logic [TL_SOURCE_WIDTH-1:0] d_source_o,
  output logic [TL_DATA_WIDTH-1:0]   d_data_o,
  output logic                       d_error_o
);

  localparam int OFF_W = $clog2(TL_STRB_WIDTH);
  localparam int MEM_AW = $clog2(MEM_DEPTH);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_ACK      = 3'd0;
  localparam logic [2:0] OP_ACK_DATA = 3'd1;

  typedef struct packed {
    logic [2:0]                 opcode;
    logic [TL_SIZE_WIDTH-1:0]   size;
    logic [TL_SOURCE_WIDTH-1:0] source;
    logic [TL_DATA_WIDTH-1:0]   data;
    logic                       error;
  } rsp_t;

  logic [TL_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  rsp_t                     rsp_mem_q [RSP_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic [TL_ADDR_WIDTH-1:0] offset;
  logic [TL_ADDR_WIDTH-1:0] align_mask;
  logic [MEM_AW-1:0]        word_idx;
  logic                     req_err;
  logic                     is_get;
  logic                     is_put;
  logic                     a_fire;
  logic                     d_fire;
  logic                     mem_we;
  rsp_t                     rsp_new;
  rsp_t                     rsp_head;
  logic                     unused_offset_bits;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Readiness depends only on queue occupancy, never on d_ready.
  assign a_ready_o = !reset_i && (cnt_q < CNT_W'(RSP_DEPTH));
  assign a_fire    = a_valid_i && a_ready_o;
  assign d_valid_o = !reset_i && (cnt_q != '0);
  assign d_fire    = d_valid_o && d_ready_i;

  assign offset             = a_address_i - BASE_ADDR;
  assign word_idx           = offset[OFF_W +: MEM_AW];
  assign align_mask         = (TL_ADDR_WIDTH'(1) << a_size_i) - TL_ADDR_WIDTH'(1);
  assign unused_offset_bits = ^offset;

  always_comb begin
    is_get  = (a_opcode_i == OP_GET);
    is_put  = (a_opcode_i == OP_PUT_FULL) || (a_opcode_i == OP_PUT_PART);
    req_err = !(is_get || is_put)
              || (a_param_i != 3'd0)
              || (a_size_i > TL_SIZE_WIDTH'(OFF_W))
              || ((a_address_i & align_mask) != '0);
`ifdef TL_UL_SLAVE_ADDR_CHECK_EN
    req_err = req_err || (a_address_i < BASE_ADDR)
              || (offset >= TL_ADDR_WIDTH'(MEM_DEPTH * TL_STRB_WIDTH));
`endif
  end

  assign mem_we = a_fire && is_put && !req_err;

  always_comb begin
    rsp_new        = '0;
    rsp_new.opcode = is_get ? OP_ACK_DATA : OP_ACK;
    rsp_new.size   = a_size_i;
    rsp_new.source = a_source_i;
    rsp_new.error  = req_err;
    rsp_new.data   = (is_get && !req_err) ? mem_q[word_idx] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < TL_STRB_WIDTH; b++) begin
        if (a_mask_i[b]) begin
          mem_q[word_idx][8*b +: 8] <= a_data_i[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (a_fire) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (d_fire) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({a_fire, d_fire})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Queue storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (a_fire) rsp_mem_q[wr_ptr_q] <= rsp_new;
  end

  assign rsp_head   = rsp_mem_q[rd_ptr_q];
  assign d_opcode_o = d_valid_o ? rsp_head.opcode : '0;
  assign d_size_o   = d_valid_o ? rsp_head.size   : '0;
  assign d_source_o = d_valid_o ? rsp_head.source : '0;
  assign d_data_o   = d_valid_o ? rsp_head.data   : '0;
  assign d_error_o  = d_valid_o ? rsp_head.error  : 1'b0;
  assign d_param_o  = '0;
  assign d_sink_o   = '0;

endmodule

// File: tb/tb_tilelink_ul_slave_mem.sv
// Bench for tilelink_ul_slave_mem: directed steps plus random traffic against a queue/array reference model.
module tb_tilelink_ul_slave_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, a_ready;
  logic [2:0]  a_opcode, a_param, a_size;
  logic [31:0] a_address, a_data;
  logic [3:0]  a_mask, a_source;
  logic        d_valid, d_ready;
  logic [2:0]  d_opcode, d_param, d_size;
  logic [0:0]  d_sink;
  logic [3:0]  d_source;
  logic [31:0] d_data;
  logic        d_error;

  always #5 clk = ~clk;

  tilelink_ul_slave_mem dut (
    .clk_i(clk), .reset_i(reset),
    .a_valid_i(a_valid), .a_ready_o(a_ready), .a_opcode_i(a_opcode), .a_param_i(a_param),
    .a_address_i(a_address), .a_size_i(a_size), .a_mask_i(a_mask), .a_data_i(a_data),
    .a_source_i(a_source),
    .d_valid_o(d_valid), .d_ready_i(d_ready), .d_opcode_o(d_opcode), .d_param_o(d_param),
    .d_size_o(d_size), .d_sink_o(d_sink), .d_source_o(d_source), .d_data_o(d_data),
    .d_error_o(d_error)
  );

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [3:0]  src;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        eq[$];
  logic [31:0] mm [256];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: expected response of the request on the A pins, plus its memory effect.
  task automatic model_accept(output exp_t r);
    bit          err;
    int unsigned idx;
    err = !(a_opcode == 3'd0 || a_opcode == 3'd1 || a_opcode == 3'd4)
          || (a_param != 0) || (a_size > 2)
          || ((a_address % (32'd1 << a_size)) != 0);
`ifdef TL_UL_SLAVE_ADDR_CHECK_EN
    err = err || (a_address >= 32'h400);
`endif
    idx    = (a_address / 4) % 256;
    r.op   = (a_opcode == 3'd4) ? 3'd1 : 3'd0;
    r.size = a_size;
    r.src  = a_source;
    r.data = 32'd0;
    r.err  = err;
    if (!err) begin
      if (a_opcode == 3'd4) r.data = mm[idx];
      else for (int b = 0; b < 4; b++) if (a_mask[b]) mm[idx][8*b +: 8] = a_data[8*b +: 8];
    end
  endtask

  task automatic drive(input bit v, input logic [2:0] op, input logic [2:0] prm,
                       input logic [31:0] addr, input logic [2:0] sz, input logic [3:0] msk,
                       input logic [31:0] dat, input logic [3:0] src);
    a_valid = v; a_opcode = op; a_param = prm; a_address = addr;
    a_size = sz; a_mask = msk; a_data = dat; a_source = src;
  endtask

  // One clock: check outputs at the falling edge, advance the model at the rising edge.
  task automatic cycle(output bit acc);
    bit   exp_rdy, exp_vld, pop;
    exp_t r;
    @(negedge clk);
    exp_rdy = !reset && (eq.size() < 2);
    exp_vld = !reset && (eq.size() != 0);
    chk("a_ready", a_ready, exp_rdy);
    chk("d_valid", d_valid, exp_vld);
    chk("d_param", d_param, 0);
    chk("d_sink", d_sink, 0);
    if (exp_vld) begin
      chk("d_opcode", d_opcode, eq[0].op);
      chk("d_size", d_size, eq[0].size);
      chk("d_source", d_source, eq[0].src);
      chk("d_data", d_data, eq[0].data);
      chk("d_error", d_error, eq[0].err);
    end else if (reset) begin
      chk("rst_d_opcode", d_opcode, 0);
      chk("rst_d_size", d_size, 0);
      chk("rst_d_source", d_source, 0);
      chk("rst_d_data", d_data, 0);
      chk("rst_d_error", d_error, 0);
    end
    acc = a_valid && exp_rdy;
    pop = exp_vld && d_ready;
    @(posedge clk);
    if (reset) begin
      eq.delete();
    end else begin
      if (pop) void'(eq.pop_front());
      if (acc) begin
        model_accept(r);
        eq.push_back(r);
      end
    end
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [2:0] prm, input logic [31:0] addr,
                      input logic [2:0] sz, input logic [3:0] msk, input logic [31:0] dat,
                      input logic [3:0] src);
    bit acc = 1'b0;
    int n = 0;
    drive(1'b1, op, prm, addr, sz, msk, dat, src);
    while (!acc && n < 8) begin
      cycle(acc);
      n++;
    end
    chk("accept_within_budget", acc, 1);
    a_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    a_valid = 1'b0;
    repeat (n) cycle(acc);
  endtask

  initial begin
    bit          acc, last_acc;
    int unsigned r, sz, off;
    reset = 1'b1;
    d_ready = 1'b1;
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    reset = 1'b0;

    // Fill every word so later reads are always defined; back-to-back, one per cycle.
    for (int i = 0; i < 256; i++) send(3'd0, 0, i * 4, 3'd2, 4'hF, $urandom, i[3:0]);
    idle(2);

    send(3'd0, 0, 32'h10, 3'd2, 4'hF, 32'hDEADBEEF, 4'd3);
    send(3'd4, 0, 32'h10, 3'd2, 4'hF, 32'h0, 4'd5);
    idle(1);
    send(3'd1, 0, 32'h10, 3'd2, 4'h3, 32'h0000_1234, 4'd6);
    send(3'd4, 0, 32'h10, 3'd2, 4'h0, 32'h0, 4'd7);
    idle(2);

    // Backpressure: third Get waits until a pop frees a slot.
    d_ready = 1'b0;
    send(3'd4, 0, 32'h10, 3'd2, 4'hF, 0, 4'd1);
    send(3'd4, 0, 32'h0, 3'd2, 4'hF, 0, 4'd2);
    drive(1'b1, 3'd4, 0, 32'h20, 3'd2, 4'hF, 0, 4'd9);
    cycle(acc);
    cycle(acc);
    d_ready = 1'b1;
    send(3'd4, 0, 32'h20, 3'd2, 4'hF, 0, 4'd9);
    idle(3);

    send(3'd2, 0, 32'h10, 3'd2, 4'hF, 32'h1111_1111, 4'd1);
    send(3'd0, 3'd1, 32'h10, 3'd2, 4'hF, 32'h2222_2222, 4'd2);
    send(3'd4, 3'd1, 32'h10, 3'd2, 4'hF, 0, 4'd3);
    send(3'd0, 0, 32'h10, 3'd3, 4'hF, 32'h3333_3333, 4'd4);
    send(3'd0, 0, 32'h12, 3'd2, 4'hF, 32'h4444_4444, 4'd5);
    send(3'd0, 0, 32'h400, 3'd2, 4'hF, 32'hCAFE_F00D, 4'd6);
    send(3'd4, 0, 32'h10, 3'd2, 4'hF, 0, 4'd7);
    send(3'd4, 0, 32'h0, 3'd2, 4'hF, 0, 4'd8);
    send(3'd0, 0, 32'h0, 3'd0, 4'h1, 32'h0000_00AB, 4'd9);
    send(3'd0, 0, 32'h7, 3'd0, 4'h8, 32'hCD00_0000, 4'd10);
    send(3'd4, 0, 32'h0, 3'd2, 4'hF, 0, 4'd11);
    send(3'd4, 0, 32'h4, 3'd2, 4'hF, 0, 4'd12);
    idle(3);

    last_acc = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!a_valid || last_acc) begin
        if ($urandom_range(0, 2) != 0) begin
          r  = $urandom_range(0, 19);
          sz = ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, 2);
          off = $urandom_range(0, 3);
          if ($urandom_range(0, 7) != 0) off = off & ~((32'd1 << sz) - 1);
          drive(1'b1,
                (r < 7) ? 3'd0 : (r < 11) ? 3'd1 : (r < 18) ? 3'd4 : 3'($urandom_range(5, 7)),
                (r == 19) ? 3'd1 : 3'd0,
                ($urandom_range(0, 511) * 4) + off, 3'(sz), 4'($urandom_range(0, 15)),
                $urandom, 4'($urandom_range(0, 15)));
        end else begin
          a_valid = 1'b0;
        end
      end
      d_ready = ($urandom_range(0, 3) != 0);
      cycle(last_acc);
    end
    d_ready = 1'b1;
    idle(4);

    // Reset with two responses queued and a request on the pins.
    d_ready = 1'b0;
    send(3'd4, 0, 32'h10, 3'd2, 4'hF, 0, 4'd8);
    send(3'd4, 0, 32'h14, 3'd2, 4'hF, 0, 4'd9);
    reset = 1'b1;
    drive(1'b1, 3'd0, 0, 32'h20, 3'd2, 4'hF, 32'h5555_AAAA, 4'd1);
    cycle(acc);
    reset = 1'b0;
    d_ready = 1'b1;
    idle(3);
    send(3'd4, 0, 32'h20, 3'd2, 4'hF, 0, 4'd2);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
